// File: rtl/cam_pkg.sv
// cam_pkg: shared colours, screen size, pattern encodings, FSM states and RGB565 expansion
package cam_pkg;
  localparam int SCREEN_WIDTH = 176;
  localparam int SCREEN_HEIGHT = 144;
  localparam int BAR_W = 22;
  localparam logic [7:0] RED = 8'hE0;
  localparam logic [7:0] GREEN = 8'h1C;
  localparam logic [7:0] BLUE = 8'h03;
  localparam logic [7:0] BLACK = 8'h00;
  localparam logic [7:0] WHITE = 8'hFF;
  localparam logic [7:0] YELLOW = 8'hFC;
  localparam logic [7:0] PURPLE = 8'hE3;
  localparam logic [7:0] LIGHTBLUE = 8'h0B;
  localparam logic [7:0] BROWN = 8'h8C;
  typedef enum logic [1:0] {PAT_MEM, PAT_BARS, PAT_SOLID, PAT_GRAD} pat_t;
  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT} state_t;
  function automatic logic [15:0] rgb332_to_565(input logic [7:0] c);
    return {c[7:5], c[7:6], c[4:2], c[4:2], c[1:0], c[1:0], c[1]};
  endfunction
endpackage

// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: combinational RGB332 pixel source for the stream emulator
module cam_pattern_gen
  import cam_pkg::*;
(
  input  logic [7:0] col,
  input  logic [7:0] row,
  input  pat_t       pat_sel,
  input  logic [7:0] solid_color,
  input  logic [7:0] rd_data,
  output logic [7:0] pixel
);
  localparam logic [63:0] BARS = {BLACK, BROWN, BLUE, PURPLE, GREEN, YELLOW, LIGHTBLUE, WHITE};
  logic [2:0] bar;
  // pick the pixel from memory, bar table, solid colour or diagonal gradient
  always_comb begin
    bar = 3'(col / 8'(BAR_W));
    pixel = pat_sel == PAT_MEM ? rd_data :
            pat_sel == PAT_BARS ? BARS[{bar, 3'b000} +: 8] :
            pat_sel == PAT_SOLID ? solid_color : col + row;
  end
endmodule

// File: rtl/camera_stream_emulator.sv
// camera_stream_emulator: OV7670-style PCLK/HREF/VSYNC/data transmitter for loopback bring-up
module camera_stream_emulator
  import cam_pkg::*;
#(
  parameter int H_PIXELS     = SCREEN_WIDTH,
  parameter int V_LINES      = SCREEN_HEIGHT,
  parameter int HBLANK_PCLK  = 32,
  parameter int VSYNC_LINES  = 3,
  parameter int VBACK_LINES  = 17,
  parameter int VFRONT_LINES = 10,
  parameter int ADDR_W       = 15
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              enable,
  input  logic [1:0]        pat_sel,
  input  logic [7:0]        solid_color,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              PCLK_OUT,
  output logic              HREF_OUT,
  output logic              VSYNC_OUT,
  output logic [7:0]        DATA_OUT,
  output logic              busy,
  output logic              frame_done
);
  localparam int LP = 2 * H_PIXELS + HBLANK_PCLK;
  localparam logic [15:0] VS_END = 16'(VSYNC_LINES * LP - 1);
  localparam logic [15:0] VB_END = 16'(VBACK_LINES * LP - 1);
  localparam logic [15:0] VB_PRE = 16'(VBACK_LINES * LP - 2);
  localparam logic [15:0] HB_END = 16'(HBLANK_PCLK - 1);
  localparam logic [15:0] HB_PRE = 16'(HBLANK_PCLK - 2);
  localparam logic [15:0] VF_END = 16'(VFRONT_LINES * LP - 1);
  localparam logic [15:0] ACT_END = 16'(2 * H_PIXELS - 1);
  localparam logic [7:0] V_END = 8'(V_LINES);
  localparam logic [7:0] COL_LAST = 8'(H_PIXELS - 1);
  state_t state;
  logic ph;
  logic [15:0] pcnt;
  logic [7:0] col, row, solid_q, pix, lo_q;
  logic [15:0] pix565;
  pat_t pat_q;
  function automatic logic [ADDR_W-1:0] addr(input logic [7:0] r, input logic [7:0] c);
    return ADDR_W'(int'(r) * H_PIXELS + int'(c));
  endfunction
  cam_pattern_gen u_pat (
    .col(col), .row(row), .pat_sel(pat_q), .solid_color(solid_q), .rd_data(rd_data), .pixel(pix)
  );
  assign pix565 = rgb332_to_565(pix);
  assign PCLK_OUT = ph;
  // frame sequencer: outputs only move on the PCLK falling boundary (ph 1->0)
  always_ff @(posedge CLOCK)
    if (RESET) begin
      state <= S_IDLE;
      ph <= 1'b0;
      pcnt <= '0;
      col <= '0;
      row <= '0;
      pat_q <= PAT_MEM;
      solid_q <= '0;
      lo_q <= '0;
      rd_addr <= '0;
      HREF_OUT <= 1'b0;
      VSYNC_OUT <= 1'b0;
      DATA_OUT <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ph <= ~ph;
      frame_done <= 1'b0;
      if (ph) begin
        pcnt <= pcnt + 16'd1;
        case (state)
          S_IDLE, S_VFRONT:
            if (state == S_IDLE || pcnt == VF_END) begin
              frame_done <= state == S_VFRONT;
              if (enable) begin
                state <= S_VSYNC;
                VSYNC_OUT <= 1'b1;
                busy <= 1'b1;
                pcnt <= '0;
                row <= '0;
                col <= '0;
                pat_q <= pat_t'(pat_sel);
                solid_q <= solid_color;
              end else begin
                state <= S_IDLE;
                busy <= 1'b0;
              end
            end
          S_VSYNC:
            if (pcnt == VS_END) begin
              state <= S_VBACK;
              VSYNC_OUT <= 1'b0;
              pcnt <= '0;
            end
          S_VBACK, S_HBLANK: begin
            if (pcnt == (state == S_VBACK ? VB_PRE : HB_PRE) && row != V_END)
              rd_addr <= addr(row, 8'd0);
            if (pcnt == (state == S_VBACK ? VB_END : HB_END)) begin
              pcnt <= '0;
              if (row == V_END) state <= S_VFRONT;
              else begin
                state <= S_ACTIVE;
                HREF_OUT <= 1'b1;
                DATA_OUT <= pix565[15:8];
                lo_q <= pix565[7:0];
              end
            end
          end
          S_ACTIVE:
            if (pcnt == ACT_END) begin
              state <= S_HBLANK;
              HREF_OUT <= 1'b0;
              DATA_OUT <= '0;
              pcnt <= '0;
              row <= row + 8'd1;
              col <= '0;
            end else if (!pcnt[0]) begin
              DATA_OUT <= lo_q;
              col <= col + 8'd1;
              if (col != COL_LAST) rd_addr <= addr(row, col + 8'd1);
            end else begin
              DATA_OUT <= pix565[15:8];
              lo_q <= pix565[7:0];
            end
          default: state <= S_IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_camera_stream_emulator.sv
// tb_camera_stream_emulator: randomized frame checks against a period-level reference model
module tb_camera_stream_emulator;
  localparam int H = 176, V = 3, HB = 8, VS = 1, VB = 2, VF = 1, AW = 15;
  localparam int LP = 2 * H + HB;
  localparam int FP = (VS + VB + V + VF) * LP;
  logic CLOCK = 1'b0, RESET, enable;
  logic [1:0] pat_sel;
  logic [7:0] solid_color, rd_data = 8'h00, DATA_OUT;
  logic [AW-1:0] rd_addr;
  logic PCLK_OUT, HREF_OUT, VSYNC_OUT, busy, frame_done;
  logic [7:0] mem [H*V];
  int checks = 0, errors = 0;
  int bad [8], bp [8], ba [8], be [8];
  string names [8] = '{"vsync", "href", "data", "rd_addr", "recover", "busy", "frame_done_early", "pclk"};

  camera_stream_emulator #(
    .H_PIXELS(H), .V_LINES(V), .HBLANK_PCLK(HB), .VSYNC_LINES(VS),
    .VBACK_LINES(VB), .VFRONT_LINES(VF), .ADDR_W(AW)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .enable(enable), .pat_sel(pat_sel), .solid_color(solid_color),
    .rd_addr(rd_addr), .rd_data(rd_data), .PCLK_OUT(PCLK_OUT), .HREF_OUT(HREF_OUT),
    .VSYNC_OUT(VSYNC_OUT), .DATA_OUT(DATA_OUT), .busy(busy), .frame_done(frame_done)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) rd_data <= int'(rd_addr) < H * V ? mem[rd_addr] : 8'h00;

  function automatic logic [7:0] bar_color(input int col);
    case (col / 22)
      0: return 8'hFF;
      1: return 8'h0B;
      2: return 8'hFC;
      3: return 8'h1C;
      4: return 8'hE3;
      5: return 8'h03;
      6: return 8'h8C;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ref_pixel(input int pat, input logic [7:0] sol, input int col, input int row);
    case (pat)
      0: return mem[row * H + col];
      1: return bar_color(col);
      2: return sol;
      default: return 8'((col + row) % 256);
    endcase
  endfunction

  function automatic logic [15:0] expand(input logic [7:0] c);
    int r, g, b;
    r = int'(c[7:5]);
    g = int'(c[4:2]);
    b = int'(c[1:0]);
    return 16'((r * 4 + r / 2) * 2048 + g * 9 * 32 + b * 10 + b / 2);
  endfunction

  task automatic note(input int k, input int p, input int act, input int exp);
    if (bad[k] == 0) begin
      bp[k] = p;
      ba[k] = act;
      be[k] = exp;
    end
    bad[k]++;
  endtask

  task automatic check_frame(input int pat, input logic [7:0] sol, input int npat, input logic [7:0] nsol, input bit nen);
    int t, line, pos, al, np, nl, npos, ea;
    logic [15:0] px;
    logic [7:0] eb, first_b, rec;
    logic [AW-1:0] a0;
    logic fd0, pc0, ev, eh;
    for (int k = 0; k < 8; k++) bad[k] = 0;
    t = 0;
    while (VSYNC_OUT !== 1'b1 && t < 4 * LP) begin
      @(negedge CLOCK);
      t++;
    end
    checks++;
    if (VSYNC_OUT !== 1'b1) begin
      errors++;
      $display("FAIL vsync_start: VSYNC_OUT=%b after %0d clocks, expected 1", VSYNC_OUT, t);
      return;
    end
    first_b = 8'h00;
    for (int p = 0; p < FP; p++) begin
      a0 = rd_addr;
      fd0 = frame_done;
      pc0 = PCLK_OUT;
      @(negedge CLOCK);
      line = p / LP;
      pos = p % LP;
      al = line - VS - VB;
      ev = line < VS;
      eh = al >= 0 && al < V && pos < 2 * H;
      px = eh ? expand(ref_pixel(pat, sol, pos / 2, al)) : 16'h0000;
      eb = !eh ? 8'h00 : pos % 2 == 0 ? px[15:8] : px[7:0];
      if (pc0 !== 1'b0 || PCLK_OUT !== 1'b1) note(7, p, int'({pc0, PCLK_OUT}), 1);
      if (VSYNC_OUT !== ev) note(0, p, int'(VSYNC_OUT), int'(ev));
      if (HREF_OUT !== eh) note(1, p, int'(HREF_OUT), int'(eh));
      if (DATA_OUT !== eb) note(2, p, int'(DATA_OUT), int'(eb));
      if (busy !== 1'b1) note(5, p, int'(busy), 1);
      if ((p > 0 && fd0 !== 1'b0) || frame_done !== 1'b0) note(6, p, 1, 0);
      if (eh && pos % 2 == 0) first_b = DATA_OUT;
      if (eh && pos % 2 == 1) begin
        rec = {first_b[7:5], first_b[2:0], DATA_OUT[4:3]};
        if (rec !== ref_pixel(pat, sol, pos / 2, al)) note(4, p, int'(rec), int'(ref_pixel(pat, sol, pos / 2, al)));
      end
      np = p + 1;
      nl = np / LP - VS - VB;
      npos = np % LP;
      if (nl >= 0 && nl < V && npos < 2 * H && npos % 2 == 0) begin
        ea = nl * H + npos / 2;
        if (int'(a0) !== ea || int'(rd_addr) !== ea) note(3, p, int'(rd_addr), ea);
      end
      if (p == (VS + VB + 1) * LP + 5) begin
        pat_sel = 2'(npat);
        solid_color = nsol;
        enable = nen;
      end
      @(negedge CLOCK);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bad[k] != 0) begin
        errors++;
        $display("FAIL %s (pat %0d): %0d bad periods, first at period %0d got 0x%0h expected 0x%0h",
                 names[k], pat, bad[k], bp[k], ba[k], be[k]);
      end
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL frame_done_end: got %b expected 1", frame_done);
    end
    checks++;
    if (VSYNC_OUT !== nen || busy !== nen) begin
      errors++;
      $display("FAIL next_frame: VSYNC_OUT=%b busy=%b expected %b", VSYNC_OUT, busy, nen);
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    checks += 7;
    if (PCLK_OUT !== 1'b0) begin errors++; $display("FAIL reset_pclk: got %b expected 0", PCLK_OUT); end
    if (HREF_OUT !== 1'b0) begin errors++; $display("FAIL reset_href: got %b expected 0", HREF_OUT); end
    if (VSYNC_OUT !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b expected 0", VSYNC_OUT); end
    if (DATA_OUT !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", DATA_OUT); end
    if (rd_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", rd_addr); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    RESET = 1'b0;
    repeat (20) @(negedge CLOCK);
    checks += 2;
    if (VSYNC_OUT !== 1'b0) begin errors++; $display("FAIL idle_vsync: got %b expected 0", VSYNC_OUT); end
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_solid;
    pat_sel = 2'd2;
    solid_color = 8'hE0;
    enable = 1'b1;
    check_frame(2, 8'hE0, 2, 8'hFF, 1'b1);
    check_frame(2, 8'hFF, 1, 8'($urandom), 1'b1);
  endtask

  task automatic test_bars;
    check_frame(1, solid_color, 3, 8'($urandom), 1'b1);
  endtask

  task automatic test_gradient;
    check_frame(3, solid_color, 0, 8'h00, 1'b1);
  endtask

  task automatic test_memory;
    check_frame(0, 8'h00, 0, 8'h00, 1'b1);
  endtask

  task automatic test_enable_drop;
    int viol;
    check_frame(0, 8'h00, 2, 8'hFF, 1'b0);
    viol = 0;
    repeat (3000) begin
      @(negedge CLOCK);
      if (VSYNC_OUT !== 1'b0 || busy !== 1'b0 || HREF_OUT !== 1'b0) viol++;
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL idle_after_drop: %0d active samples, expected 0", viol);
    end
  endtask

  task automatic test_reset_mid;
    int t;
    enable = 1'b1;
    t = 0;
    while (HREF_OUT !== 1'b1 && t < 2 * FP) begin
      @(negedge CLOCK);
      t++;
    end
    checks++;
    if (HREF_OUT !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_href: HREF_OUT=%b after %0d clocks, expected 1", HREF_OUT, t);
    end
    repeat (2) @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    checks++;
    if ({PCLK_OUT, HREF_OUT, VSYNC_OUT, busy, frame_done} !== 5'b0 || DATA_OUT !== 8'h00 || rd_addr !== '0) begin
      errors++;
      $display("FAIL reset_mid: pclk=%b href=%b vsync=%b busy=%b fd=%b data=%h addr=%h, expected all 0",
               PCLK_OUT, HREF_OUT, VSYNC_OUT, busy, frame_done, DATA_OUT, rd_addr);
    end
    RESET = 1'b0;
    check_frame(2, 8'hFF, 2, 8'hFF, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < H * V; i++) mem[i] = 8'($urandom);
    pat_sel = 2'd0;
    solid_color = 8'h00;
    test_reset();
    test_solid();
    test_bars();
    test_gradient();
    test_memory();
    test_enable_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
